// File: rtl/m_dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// m_dmem_responder_pkg
//  Shared definitions for the data-memory responder: FSM state encoding,
//  the latency ceiling imposed by the 4-bit wait counter, and the address
//  fault check used on the accept path.
// -----------------------------------------------------------------------------
package m_dmem_responder_pkg;

   // Largest LATENCY the 4-bit counter can express without wrapping.
   localparam int LAT_MAX = 15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Access fault: not word aligned, or word index beyond the array.
   function automatic logic f_addr_fault(input logic [31:0] addr, input int unsigned depth);
      logic [31:0] word_idx;
      word_idx = {2'b00, addr[31:2]};
      return (addr[1:0] != 2'b00) || (word_idx >= depth);
   endfunction

endpackage

// File: rtl/m_dmem_responder_if.sv
// -----------------------------------------------------------------------------
// m_dmem_responder_if
//  Load/store request + response handshake between the pipeline's MA stage
//  (master) and the memory responder (slave).
//  Request : w_req_valid, w_req_ready, w_req_we, w_req_addr[31:0], w_req_wdata[31:0]
//  Response: r_rsp_valid, w_rsp_ready, r_rsp_rdata[31:0], r_rsp_err
// -----------------------------------------------------------------------------
interface m_dmem_responder_if;
   logic        w_req_valid;
   logic        w_req_ready;
   logic        w_req_we;
   logic [31:0] w_req_addr;
   logic [31:0] w_req_wdata;
   logic        r_rsp_valid;
   logic        w_rsp_ready;
   logic [31:0] r_rsp_rdata;
   logic        r_rsp_err;

   modport master (
      output w_req_valid, w_req_we, w_req_addr, w_req_wdata, w_rsp_ready,
      input  w_req_ready, r_rsp_valid, r_rsp_rdata, r_rsp_err
   );

   modport slave (
      input  w_req_valid, w_req_we, w_req_addr, w_req_wdata, w_rsp_ready,
      output w_req_ready, r_rsp_valid, r_rsp_rdata, r_rsp_err
   );
endinterface

// File: rtl/m_dmem_responder_array.sv
// -----------------------------------------------------------------------------
// m_dmem_responder_array
//  DEPTH x 32-bit single-port storage: synchronous write, asynchronous read,
//  contents zero at time 0.
//  Ports: w_clock (clock), i_we (write enable), i_addr[AW-1:0] (word index),
//         i_wdata[31:0] (write data), o_rdata[31:0] (read data at i_addr)
// -----------------------------------------------------------------------------
module m_dmem_responder_array #(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          w_clock,
   input  logic          i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   // NOTE: storage has no reset port; contents survive w_reset and are only
   // zeroed by the power-up initial value, so it maps onto plain RAM.
   logic [31:0] r_mem [DEPTH] = '{default: '0};

   always_ff @(posedge w_clock) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/m_dmem_responder.sv
// -----------------------------------------------------------------------------
// m_dmem_responder
//  Memory-side responder for the core's load/store port. Accepts one request
//  at a time, commits stores / reads loads on the accept edge, and presents
//  the response LATENCY edges later, held until the initiator takes it.
//  Ports: w_clock (clock), w_reset (sync, active-high reset),
//         bus (m_dmem_responder_if.slave: request and response handshake)
//  Parameters: DEPTH (words, power of 2, 4..1024), LATENCY (1..15)
//  Build option: DMEM_RSP_BACK2BACK_EN -- accept a new request on the same
//    edge that a response is handed off, removing the idle bubble.
// -----------------------------------------------------------------------------
module m_dmem_responder
   import m_dmem_responder_pkg::*;
#(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic                 w_clock,
   input  logic                 w_reset,
   m_dmem_responder_if.slave    bus
);

   localparam int AW = $clog2(DEPTH);

   state_e      r_state, w_state_nxt;
   logic [3:0]  r_cnt, w_cnt_nxt;
   logic        r_rsp_valid;
   logic [31:0] r_rsp_rdata;
   logic        r_rsp_err;

   logic        w_req_ready;
   logic        w_accept;
   logic        w_fault;
   logic        w_hs;
   logic        w_mem_we;
   logic [31:0] w_mem_rdata;

   assign w_fault  = f_addr_fault(bus.w_req_addr, DEPTH);
   assign w_hs     = r_rsp_valid & bus.w_rsp_ready;

`ifdef DMEM_RSP_BACK2BACK_EN
   assign w_req_ready = (r_state == ST_IDLE) | ((r_state == ST_RESP) & w_hs);
`else
   assign w_req_ready = (r_state == ST_IDLE);
`endif

   assign w_accept = w_req_ready & bus.w_req_valid;
   // Faulting stores must not touch the array: the truncated index would alias.
   assign w_mem_we = w_accept & bus.w_req_we & ~w_fault;

   m_dmem_responder_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
      .w_clock (w_clock),
      .i_we    (w_mem_we),
      .i_addr  (bus.w_req_addr[AW+1:2]),
      .i_wdata (bus.w_req_wdata),
      .o_rdata (w_mem_rdata)
   );

   // NOTE: every variable gets a default before the case so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_WAIT: begin
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt == 4'd1) w_state_nxt = ST_RESP;
         end
         ST_RESP: if (w_hs) w_state_nxt = ST_IDLE;
         ST_IDLE: ;
         default: w_state_nxt = ST_IDLE;
      endcase
      // An accept (from IDLE, or from RESP on the hand-off edge) overrides.
      if (w_accept) begin
         w_cnt_nxt   = 4'(LATENCY - 1);
         w_state_nxt = (LATENCY == 1) ? ST_RESP : ST_WAIT;
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge w_clock) begin
      if (w_reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         // r_rsp_valid trails entry into RESP by one edge; that edge is the
         // final latency cycle, giving accept-to-valid of exactly LATENCY edges.
         r_rsp_valid <= (r_state == ST_RESP) & ~w_hs;
         if (w_accept) begin
            r_rsp_err   <= w_fault;
            r_rsp_rdata <= (bus.w_req_we | w_fault) ? '0 : w_mem_rdata;
         end
      end
   end

   assign bus.w_req_ready = w_req_ready;
   assign bus.r_rsp_valid = r_rsp_valid;
   assign bus.r_rsp_rdata = r_rsp_rdata;
   assign bus.r_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_m_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_m_dmem_responder
//  Directed bench for m_dmem_responder (DEPTH=64, LATENCY=2). Inputs change
//  1 time unit after the rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_m_dmem_responder;

   localparam int LAT = 2;
`ifdef DMEM_RSP_BACK2BACK_EN
   localparam int PERIOD = LAT + 1;
`else
   localparam int PERIOD = LAT + 2;
`endif

   logic w_clock = 1'b0;
   logic w_reset = 1'b1;
   always #5 w_clock = ~w_clock;

   m_dmem_responder_if bus ();

   m_dmem_responder #(.DEPTH(64), .LATENCY(LAT)) u_dut (
      .w_clock (w_clock),
      .w_reset (w_reset),
      .bus     (bus.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Edge counter and accept/response monitors for the throughput test.
   int cyc = 0;
   always @(posedge w_clock) cyc++;

   bit mon_en = 1'b0;
   int acc_q[$];
   int rsp_cnt = 0;
   int rsp_bad = 0;
   always @(negedge w_clock) begin
      if (mon_en) begin
         if (bus.w_req_valid && bus.w_req_ready) acc_q.push_back(cyc + 1);
         if (bus.r_rsp_valid && bus.w_rsp_ready) begin
            rsp_cnt++;
            if (bus.r_rsp_rdata !== 32'h1234_5678 || bus.r_rsp_err !== 1'b0) rsp_bad++;
         end
      end
   end

   task automatic tick();
      @(posedge w_clock);
      #1;
   endtask

   // Present a request while idle; returns just after the accept edge.
   task automatic start_req(input string tag, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata);
      check({tag, "_ready"}, bus.w_req_ready, 1'b1);
      bus.w_req_valid = 1'b1;
      bus.w_req_we    = we;
      bus.w_req_addr  = addr;
      bus.w_req_wdata = wdata;
      tick();
      bus.w_req_valid = 1'b0;
   endtask

   // Count edges from the accept edge until r_rsp_valid is seen (bounded).
   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!bus.r_rsp_valid && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic finish_rsp(input string tag);
      bus.w_rsp_ready = 1'b1;
      tick();
      bus.w_rsp_ready = 1'b0;
      check({tag, "_valid_drop"}, bus.r_rsp_valid, 1'b0);
   endtask

   task automatic do_access(input string tag, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_rdata,
                            input logic exp_err);
      int lat;
      start_req(tag, we, addr, wdata);
      wait_rsp(lat);
      check({tag, "_lat"}, lat, LAT);
      check({tag, "_rdata"}, bus.r_rsp_rdata, exp_rdata);
      check({tag, "_err"}, bus.r_rsp_err, exp_err);
      finish_rsp(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      bit seen;
      bus.w_req_valid = 1'b0;
      bus.w_req_we    = 1'b0;
      bus.w_req_addr  = '0;
      bus.w_req_wdata = '0;
      bus.w_rsp_ready = 1'b0;

      // Reset held for two edges.
      tick();
      tick();
      w_reset = 1'b0;
      check("rst_ready", bus.w_req_ready, 1'b1);
      check("rst_valid", bus.r_rsp_valid, 1'b0);
      check("rst_rdata", bus.r_rsp_rdata, 32'h0);
      check("rst_err",   bus.r_rsp_err,   1'b0);

      // Store then load back.
      do_access("st10", 1'b1, 32'h10, 32'h1234_5678, 32'h0, 1'b0);
      do_access("ld10", 1'b0, 32'h10, 32'h0, 32'h1234_5678, 1'b0);

      // Faults: misaligned and out of range, loads and stores.
      do_access("ld11",  1'b0, 32'h11,  32'h0, 32'h0, 1'b1);
      do_access("ld100", 1'b0, 32'h100, 32'h0, 32'h0, 1'b1);
      do_access("st11",  1'b1, 32'h11,  32'hDEAD_0011, 32'h0, 1'b1);
      do_access("st100", 1'b1, 32'h100, 32'hBEEF_0100, 32'h0, 1'b1);
      do_access("ld10b", 1'b0, 32'h10,  32'h0, 32'h1234_5678, 1'b0);
      do_access("ld0",   1'b0, 32'h0,   32'h0, 32'h0, 1'b0);

      // Backpressure: response held for 5 cycles, competing request ignored.
      start_req("bp", 1'b0, 32'h10, 32'h0);
      wait_rsp(lat);
      check("bp_lat", lat, LAT);
      bus.w_req_valid = 1'b1;
      bus.w_req_we    = 1'b1;
      bus.w_req_addr  = 32'h10;
      bus.w_req_wdata = 32'hFFFF_FFFF;
      for (int i = 0; i < 5; i++) begin
         check("bp_ready", bus.w_req_ready, 1'b0);
         tick();
         check("bp_valid", bus.r_rsp_valid, 1'b1);
         check("bp_rdata", bus.r_rsp_rdata, 32'h1234_5678);
         check("bp_err",   bus.r_rsp_err,   1'b0);
      end
      bus.w_req_valid = 1'b0;
      finish_rsp("bp");
      do_access("ld10c", 1'b0, 32'h10, 32'h0, 32'h1234_5678, 1'b0);

      // Reset while waiting: response dropped, store stays committed.
      start_req("rstw", 1'b1, 32'h8, 32'h0000_00A5);
      w_reset = 1'b1;
      tick();
      tick();
      w_reset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (bus.r_rsp_valid) seen = 1'b1;
         tick();
      end
      check("rstw_no_valid", seen, 1'b0);
      check("rstw_ready", bus.w_req_ready, 1'b1);
      do_access("ld8", 1'b0, 32'h8, 32'h0, 32'h0000_00A5, 1'b0);

      // Continuous loads with the initiator always ready.
      mon_en = 1'b1;
      bus.w_req_valid = 1'b1;
      bus.w_req_we    = 1'b0;
      bus.w_req_addr  = 32'h10;
      bus.w_rsp_ready = 1'b1;
      repeat (14) tick();
      bus.w_req_valid = 1'b0;
      for (int i = 0; i < 20 && !(bus.w_req_ready && !bus.r_rsp_valid); i++) tick();
      tick();
      mon_en = 1'b0;
      bus.w_rsp_ready = 1'b0;
      check("b2b_acc_cnt_ge3", (acc_q.size() >= 3), 1'b1);
      if (acc_q.size() >= 3) begin
         check("b2b_period0", acc_q[1] - acc_q[0], PERIOD);
         check("b2b_period1", acc_q[2] - acc_q[1], PERIOD);
      end
      check("b2b_rsp_cnt", rsp_cnt, acc_q.size());
      check("b2b_rsp_bad", rsp_bad, 0);
      check("end_idle", bus.w_req_ready, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
